// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the core data port
// and the single-port D-memory SRAM; stalls the core with CACHE_MISS during line moves.
module d_cache_ctrl #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        CACHE_CSN,
  input  logic        CACHE_WEN,
  input  logic [11:0] CACHE_ADDR,
  input  logic [31:0] CACHE_DI,
  output logic [31:0] CACHE_DOUT,
  output logic        CACHE_MISS,
  output logic        D_MEM_CSN,
  output logic        D_MEM_WEN,
  output logic [3:0]  D_MEM_BE,
  output logic [11:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_DOUT,
  input  logic [31:0] D_MEM_DI,
  output logic [31:0] hitnum,
  output logic [31:0] missnum
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = 12 - IW - OW;

  typedef enum logic [1:0] {IDLE, WB, FILL, FILL_LAST} state_t;

  state_t          state, next;
  logic [OW-1:0]   cnt, cnt_prev;
  logic [LINES-1:0] valid, dirty;
  logic [TW-1:0]   tags [LINES];
  logic [31:0]     data [LINES][WORDS];
  logic            replay;

  logic [TW-1:0]   tg;
  logic [IW-1:0]   idx;
  logic [OW-1:0]   off;
  logic            req, hit, cnt_last;

  assign tg       = CACHE_ADDR[11:IW+OW];
  assign idx      = CACHE_ADDR[IW+OW-1:OW];
  assign off      = CACHE_ADDR[OW-1:0];
  assign req      = !CACHE_CSN;
  assign hit      = valid[idx] && (tags[idx] == tg);
  assign cnt_last = (cnt == OW'(WORDS - 1));
  assign cnt_prev = cnt - 1'b1;
  assign D_MEM_BE = '0;

  always_comb begin
    next       = state;
    CACHE_MISS = 1'b0;
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          CACHE_MISS = 1'b1;
          next       = (valid[idx] && dirty[idx]) ? WB : FILL;
        end
      end
      WB: begin
        CACHE_MISS = 1'b1;
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = 1'b0;
        D_MEM_ADDR = {tags[idx], idx, cnt};
        D_MEM_DOUT = data[idx][cnt];
        if (cnt_last) next = FILL;
      end
      FILL: begin
        CACHE_MISS = 1'b1;
        D_MEM_CSN  = 1'b0;
        D_MEM_ADDR = {tg, idx, cnt};
        if (cnt_last) next = FILL_LAST;
      end
      FILL_LAST: begin
        CACHE_MISS = 1'b1;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= '0;
      dirty      <= '0;
      replay     <= 1'b0;
      hitnum     <= '0;
      missnum    <= '0;
      CACHE_DOUT <= '0;
    end else begin
      state  <= next;
      cnt    <= (state == WB || state == FILL) ? cnt + 1'b1 : '0;
      // The cycle after FILL_LAST is the replayed request; it must not count as a hit.
      replay <= (state == FILL_LAST);
      if (state == IDLE && req) begin
        if (hit) begin
          if (CACHE_WEN) CACHE_DOUT <= data[idx][off];
          else           dirty[idx] <= 1'b1;
          if (!replay && hitnum != '1) hitnum <= hitnum + 1'b1;
        end else begin
          valid[idx] <= 1'b0;
          if (missnum != '1) missnum <= missnum + 1'b1;
        end
      end
      if (state == FILL_LAST) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
        tags[idx]  <= tg;
      end
    end
  end

  // Refill data lags the read issue by one cycle, hence the cnt-1 capture slot.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      if (state == IDLE && req && hit && !CACHE_WEN) data[idx][off] <= CACHE_DI;
      if (state == FILL && cnt != '0)                data[idx][cnt_prev] <= D_MEM_DI;
      if (state == FILL_LAST)                        data[idx][OW'(WORDS - 1)] <= D_MEM_DI;
    end
  end

endmodule

// File: doc/d_cache_ctrl.md
# d_cache_ctrl

Direct-mapped, write-back, write-allocate data cache between the RISC-V core's data port and the single-port D-memory SRAM. On a hit it serves core word reads and writes from internal storage. On a miss it raises `CACHE_MISS` to stall the core, writes back a dirty victim line, then refills the line from D-memory. It keeps 32-bit hit and miss counters that the testbench prints at HALT.

## Interface
- `LINES`, 8: number of cache lines (index width = log2(LINES) = 3).
- `WORDS`, 4: 32-bit words per line (offset width = 2).
- `CLK`  in  1  clock.
- `RSTn`  in  1  reset, synchronous, active-low.
- `CACHE_CSN`  in  1  core request, active-low.
- `CACHE_WEN`  in  1  0 = write, 1 = read.
- `CACHE_ADDR`  in  12  word address: tag [11:5], index [4:2], offset [1:0].
- `CACHE_DI`  in  32  core write data.
- `CACHE_DOUT`  out  32  read data to core.
- `CACHE_MISS`  out  1  stall; core holds its request while this is high.
- `D_MEM_CSN`  out  1  D-memory chip select, active-low.
- `D_MEM_WEN`  out  1  D-memory write enable, active-low.
- `D_MEM_BE`  out  4  byte enables, constant 4'b0000 (all bytes, active-low).
- `D_MEM_ADDR`  out  12  D-memory word address.
- `D_MEM_DOUT`  out  32  write data to D-memory.
- `D_MEM_DI`  in  32  read data from D-memory (valid 1 cycle after read issue).
- `hitnum`  out  32  hit count.
- `missnum`  out  32  miss count.

## Operation
- Per line: valid, dirty, 7-bit tag, 4×32 data.
- States: IDLE, WB, FILL, FILL_LAST.
- IDLE, request with CSN=0:
  - Hit (valid and tag match), read: the word is registered onto `CACHE_DOUT`.
  - Hit, write: the word is updated and dirty is set.
  - Miss: `CACHE_MISS`=1 combinationally in the same cycle. Next state is WB if the victim is valid and dirty, else FILL.
- WB: 4 cycles, k=0..3.
  - `D_MEM_CSN`=0, `D_MEM_WEN`=0, `D_MEM_ADDR`={victim tag, index, k}, `D_MEM_DOUT`=victim word k.
  - Then go to FILL.
- FILL: 4 cycles issuing reads, k=0..3.
  - `D_MEM_CSN`=0, `D_MEM_WEN`=1, `D_MEM_ADDR`={new tag, index, k}.
  - Word k-1 is captured from `D_MEM_DI` each cycle after the first.
- FILL_LAST: capture word 3, set tag, valid=1, dirty=0, go to IDLE.
  - The stalled request then replays in IDLE as a hit: a read returns data, a write merges and sets dirty.
- Outside WB and FILL: `D_MEM_CSN`=1, `D_MEM_WEN`=1.
- Counters:
  - `missnum` increments once, in the detect cycle.
  - `hitnum` increments for each IDLE hit cycle, except the replay cycle that completes a miss (tracked with a replay flag).
  - Both saturate at 32'hFFFFFFFF.
- `CACHE_MISS` is high in every WB, FILL and FILL_LAST cycle.

## Timing
- Hit latency: read data appears on `CACHE_DOUT` at the edge after the request (SRAM-equivalent). A write takes effect at the request edge.
- Clean miss: `CACHE_MISS` high 6 cycles (detect + 4 FILL + FILL_LAST). The request completes in the 7th cycle.
- Dirty miss: `CACHE_MISS` high 10 cycles.
- Back-to-back hits: one per cycle, no bubbles.
- A read hit that follows a write hit to the same word returns the new data.
- Reset:
  - State IDLE.
  - All valid and dirty bits = 0.
  - `hitnum`=`missnum`=0, `CACHE_DOUT`=0, `CACHE_MISS`=0, `D_MEM_CSN`=1, `D_MEM_WEN`=1, `D_MEM_ADDR`=0, `D_MEM_DOUT`=0.
- Reset mid-WB or mid-FILL:
  - Aborts immediately; dirty data is discarded.
  - The line remains invalid.
  - `D_MEM_CSN`=1 from the next cycle.
- `CACHE_ADDR`, `CACHE_WEN` and `CACHE_DI` must be stable while `CACHE_MISS`=1. A change during a stall is undefined; the bench must not do it.
- CSN=1 in IDLE: no action, no count.

## Test plan
- Reset, then read 0x010 (D-mem preloaded with 0x010+k at words 0x010..0x013) -> `CACHE_MISS` high 6 cycles, four D-mem reads at 0x010..0x013, `CACHE_DOUT`=0x00000010, missnum=1, hitnum=0.
- Then read 0x011, 0x012, 0x013 on consecutive cycles -> no stall, data 0x11, 0x12, 0x13, hitnum=3.
- Write 0xDEADBEEF to 0x011, then read 0x011 -> hit, `CACHE_DOUT`=0xDEADBEEF, no D-mem access.
- Read 0x111 (same index, tag differs) -> 10-cycle stall. Write-back of 0x010..0x013 with word 0x011=0xDEADBEEF, then refill from 0x110. missnum=2, D-mem[0x011]=0xDEADBEEF.
- Assert RSTn=0 in the 2nd FILL cycle of a miss -> next cycle `D_MEM_CSN`=1, counters 0. Re-reading the same address misses again.
- Run the forloop program to HALT -> all 17 checkpoints pass, hitnum+missnum equals the number of core data accesses.
